i2s_sample_window: RTL and testbench

I2S_SAMPLE_WINDOW -- requirements
Module: i2s_sample_window

---
 rtl/i2s_pkg.sv | 16 +
 rtl/sample_shift_window.sv | 20 ++
 rtl/i2s_sample_window.sv | 91 +++++++++
 tb/tb_i2s_sample_window.sv | 134 +++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S window constants, channel encoding and sample extension helper
package i2s_pkg;
  localparam int SLOT_W_DEFAULT = 32;
  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} ch_e;
  function automatic logic [63:0] extend_sample(
    input logic [63:0] raw,
    input int unsigned sw,
    input logic        sign_ext
  );
    logic [63:0] mask;
    logic        msb;
    mask = (64'd1 << sw) - 64'd1;
    msb  = |(raw & (64'd1 << (sw - 1)));
    return (sign_ext && msb) ? (raw | ~mask) : (raw & mask);
  endfunction
endpackage

// File: rtl/sample_shift_window.sv
// sample_shift_window: per-channel history, element 0 newest, oldest falls off the top
module sample_shift_window #(
  parameter int DEPTH = 16,
  parameter int OUT_W = 16
) (
  input  logic                   BCLK_out,
  input  logic                   reset,
  input  logic                   shift_i,
  input  logic [OUT_W-1:0]       din_i,
  output logic [DEPTH*OUT_W-1:0] win_o
);
  logic [DEPTH*OUT_W-1:0] win_q, win_d;
  // truncating the concatenation drops the oldest element and inserts the new one at index 0
  always_comb win_d = shift_i ? (DEPTH*OUT_W)'({win_q, din_i}) : win_q;
  // window register, cleared by the synchronous active-low reset
  always_ff @(posedge BCLK_out)
    if (!reset) win_q <= '0;
    else win_q <= win_d;
  assign win_o = win_q;
endmodule

// File: rtl/i2s_sample_window.sv
// i2s_sample_window: I2S receiver that captures mic samples into per-channel sliding windows
module i2s_sample_window
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 10,
  parameter int SLOT_W   = SLOT_W_DEFAULT,
  parameter int DEPTH    = 16,
  parameter int OUT_W    = 16,
  parameter int STEREO   = 0,
  parameter int SIGN_EXT = 1
) (
  input  logic                   BCLK_out,
  input  logic                   reset,
  input  logic                   DOUT,
  input  logic                   hold,
  output logic                   LRCLK,
  output logic                   sample_valid,
  output logic                   sample_ch,
  output logic [DEPTH*OUT_W-1:0] win_l,
  output logic [DEPTH*OUT_W-1:0] win_r,
  output logic [7:0]             drop_cnt
);
  localparam int CNT_W = $clog2(SLOT_W);
  if (SAMPLE_W + 2 > SLOT_W || SAMPLE_W > OUT_W || DEPTH < 1) begin : g_bad_params
    $error("i2s_sample_window: illegal SAMPLE_W/SLOT_W/OUT_W/DEPTH combination");
  end
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                lr_q, lr_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic                sample_valid_q, sample_valid_d;
  ch_e                 sample_ch_q, sample_ch_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic                wrap, cap_slot, cap_bit, accept, acc_l;
  logic [OUT_W-1:0]    sample_ext;
  // slot timing, one-bit-delayed MSB-first capture, accept/hold/drop decisions
  always_comb begin
    wrap           = bit_cnt_q == CNT_W'(SLOT_W - 1);
    cap_slot       = !lr_q || STEREO != 0;
    cap_bit        = cap_slot && bit_cnt_q != '0 && bit_cnt_q <= CNT_W'(SAMPLE_W);
    accept         = cap_slot && bit_cnt_q == CNT_W'(SAMPLE_W + 1);
    bit_cnt_d      = wrap ? '0 : bit_cnt_q + 1'b1;
    lr_d           = wrap ? !lr_q : lr_q;
    shreg_d        = bit_cnt_q == '0 ? '0 : cap_bit ? SAMPLE_W'({shreg_q, DOUT}) : shreg_q;
    sample_valid_d = accept && !hold;
    sample_ch_d    = accept ? ch_e'(lr_q) : sample_ch_q;
    drop_cnt_d     = (accept && hold && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    acc_l          = accept && !hold && lr_q == CH_LEFT;
    sample_ext     = OUT_W'(extend_sample(64'(shreg_q), SAMPLE_W, SIGN_EXT != 0));
  end
  // control and capture state, all cleared by the synchronous active-low reset
  always_ff @(posedge BCLK_out)
    if (!reset) begin
      bit_cnt_q      <= '0;
      lr_q           <= 1'b0;
      shreg_q        <= '0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= CH_LEFT;
      drop_cnt_q     <= '0;
    end else begin
      bit_cnt_q      <= bit_cnt_d;
      lr_q           <= lr_d;
      shreg_q        <= shreg_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  sample_shift_window #(.DEPTH(DEPTH), .OUT_W(OUT_W)) u_win_l (
    .BCLK_out(BCLK_out),
    .reset   (reset),
    .shift_i (acc_l),
    .din_i   (sample_ext),
    .win_o   (win_l)
  );
  if (STEREO != 0) begin : g_right
    logic acc_r;
    assign acc_r = accept && !hold && lr_q == CH_RIGHT;
    sample_shift_window #(.DEPTH(DEPTH), .OUT_W(OUT_W)) u_win_r (
      .BCLK_out(BCLK_out),
      .reset   (reset),
      .shift_i (acc_r),
      .din_i   (sample_ext),
      .win_o   (win_r)
    );
  end else begin : g_mono
    assign win_r = '0;
  end
  assign LRCLK        = lr_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_i2s_sample_window.sv
// tb_i2s_sample_window: directed checks on mono, zero-extend and stereo instances sharing one stream
module tb_i2s_sample_window;
  logic clk = 0, rst_n = 0, dout = 0, hold = 0;
  logic d0_lr, d0_sv, d0_ch, d1_lr, d1_sv, d1_ch, d2_lr, d2_sv, d2_ch;
  logic [255:0] d0_wl, d0_wr, d1_wl, d1_wr, d2_wl, d2_wr, exp_win;
  logic [7:0] d0_drop, d1_drop, d2_drop;
  int checks = 0, errors = 0, cyc = 0, n0 = 0, pos0 = 0, n2 = 0, tot = 0, t2 = 0, t_a = 0, t_b = 0;
  logic lr_exp = 0, ch2 = 0;
  always #5 clk = ~clk;
  i2s_sample_window u_d0 (
    .BCLK_out(clk), .reset(rst_n), .DOUT(dout), .hold(hold), .LRCLK(d0_lr), .sample_valid(d0_sv),
    .sample_ch(d0_ch), .win_l(d0_wl), .win_r(d0_wr), .drop_cnt(d0_drop));
  i2s_sample_window #(.SIGN_EXT(0)) u_d1 (
    .BCLK_out(clk), .reset(rst_n), .DOUT(dout), .hold(hold), .LRCLK(d1_lr), .sample_valid(d1_sv),
    .sample_ch(d1_ch), .win_l(d1_wl), .win_r(d1_wr), .drop_cnt(d1_drop));
  i2s_sample_window #(.STEREO(1)) u_d2 (
    .BCLK_out(clk), .reset(rst_n), .DOUT(dout), .hold(hold), .LRCLK(d2_lr), .sample_valid(d2_sv),
    .sample_ch(d2_ch), .win_l(d2_wl), .win_r(d2_wr), .drop_cnt(d2_drop));
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] el(input logic [255:0] w, input int k);
    return w[k*16 +: 16];
  endfunction
  task automatic run_slot(input logic [9:0] val, input logic fill);
    n0 = 0;
    n2 = 0;
    for (int c = 0; c < 32; c++) begin
      dout = (c >= 1 && c <= 10) ? val[10-c] : fill;
      @(posedge clk);
      #1;
      cyc++;
      if (d0_sv) begin n0++; pos0 = c; end
      if (d2_sv) begin n2++; ch2 = d2_ch; t2 = cyc; end
      if (c == 30) chk("lrclk_steady", d0_lr, lr_exp);
      if (c == 31) chk("lrclk_toggle", d0_lr, !lr_exp);
    end
    tot += n0 + n2;
    lr_exp = !lr_exp;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_win_l", d0_wl, 0);
    chk("rst_win_r_stereo", d2_wr, 0);
    chk("rst_valid", d0_sv, 0);
    chk("rst_lrclk", d2_lr, 0);
    chk("rst_drop", d0_drop, 0);
    chk("rst_ch", d2_ch, 0);
    chk("rst_d1_misc", {d1_lr, d1_sv, d1_ch, d1_drop}, 0);
    chk("rst_d1_win_r", d1_wr, 0);
    rst_n = 1;
    run_slot(10'b1000000001, 0);
    chk("l1_strobes", n0, 1);
    chk("l1_strobe_pos", pos0, 11);
    chk("l1_sext", el(d0_wl, 0), 16'hFE01);
    chk("l1_zext", el(d1_wl, 0), 16'h0201);
    chk("l1_ch", ch2, 0);
    t_a = t2;
    run_slot(10'h3FF, 0);
    chk("r1_mono_no_strobe", n0, 0);
    chk("r1_mono_no_drop", d0_drop, 0);
    chk("r1_mono_win_r", d0_wr, 0);
    chk("r1_win_r", el(d2_wr, 0), 16'hFFFF);
    chk("r1_ch", ch2, 1);
    chk("r1_spacing", t2 - t_a, 32);
    t_b = t2;
    run_slot(10'h005, 0);
    chk("l2_win_l", el(d2_wl, 0), 16'h0005);
    chk("l2_win_l1", el(d2_wl, 1), 16'hFE01);
    chk("l2_ch", ch2, 0);
    chk("l2_spacing", t2 - t_b, 32);
    run_slot(10'h000, 0);
    run_slot(10'h000, 1);
    chk("fill_ignored", el(d0_wl, 0), 16'h0000);
    chk("fill_ignored_prev", el(d0_wl, 1), 16'h0005);
    run_slot(10'h000, 0);
    for (int v = 1; v <= 17; v++) begin
      run_slot(10'(v), 0);
      run_slot(10'h000, 0);
    end
    for (int k = 0; k < 16; k++) exp_win[k*16 +: 16] = 16'(17 - k);
    chk("fill17_e0", el(d0_wl, 0), 16'd17);
    chk("fill17_e15", el(d0_wl, 15), 16'd2);
    chk("fill17_all", d0_wl, exp_win);
    hold = 1;
    tot = 0;
    for (int i = 0; i < 600; i++) begin
      run_slot(10'h2AA, 0);
      if (i == 1) begin
        chk("hold_drop_mono", d0_drop, 1);
        chk("hold_drop_stereo", d2_drop, 2);
      end
    end
    chk("hold_no_strobes", tot, 0);
    chk("hold_win_l", d0_wl, exp_win);
    chk("hold_win_l_stereo", d2_wl, exp_win);
    chk("hold_win_r_stereo", d2_wr, 0);
    chk("hold_drop_sat", d0_drop, 255);
    chk("hold_drop_sat_stereo", d2_drop, 255);
    hold = 0;
    run_slot(10'h155, 0);
    chk("resume_strobe", n0, 1);
    chk("resume_e0", el(d0_wl, 0), 16'h0155);
    chk("resume_e1", el(d0_wl, 1), 16'h0011);
    chk("resume_drop_kept", d0_drop, 255);
    run_slot(10'h000, 0);
    for (int c = 0; c < 5; c++) begin
      dout = c >= 1;
      @(posedge clk);
      #1;
    end
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("midrst_outs", {d2_lr, d2_sv, d2_ch, d2_drop}, 0);
    chk("midrst_win_l", d2_wl, 0);
    chk("midrst_win_r", d2_wr, 0);
    chk("midrst_drop_mono", d0_drop, 0);
    rst_n = 1;
    lr_exp = 0;
    run_slot(10'h001, 0);
    chk("post_rst_strobes", n0, 1);
    chk("post_rst_pos", pos0, 11);
    chk("post_rst_e0", el(d0_wl, 0), 16'h0001);
    chk("post_rst_e1", el(d0_wl, 1), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
